cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/rv32i_types.sv | 17 +
 rtl/cdb_arbiter_if.sv | 33 +++
 rtl/cdb_rr_select.sv | 29 ++
 rtl/cdb_arbiter.sv | 84 ++++++++
 tb/tb_cdb_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types: FU count and the common data bus entry format.
package rv32i_types;

  localparam int TOTAL_FU = 4;
  localparam int FU_ID_W  = (TOTAL_FU > 1) ? $clog2(TOTAL_FU) : 1;
  localparam int ORDER_W  = 6;

  typedef logic [FU_ID_W-1:0] fu_id_t;

  typedef struct packed {
    fu_id_t               fu_id;
    logic [4:0]           rd;
    logic [31:0]          data;
    logic [ORDER_W-1:0]   order;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-to-CDB bus: per-FU result requests in, one registered broadcast out.
interface cdb_arbiter_if
  import rv32i_types::*;
#(
  parameter int NUM_FU = TOTAL_FU
);

  // Valid/ready: FU i asserts req_valid[i] and holds req_data[i] stable until a
  // cycle with req_valid[i] && req_ready[i]; that cycle is the transfer. The
  // consumer never back-pressures cdb_valid.
  logic [NUM_FU-1:0]              req_valid;
  cdb_entry_t [NUM_FU-1:0]        req_data;
  logic [NUM_FU-1:0]              req_ready;
  logic                           cdb_valid;
  cdb_entry_t                     cdb_data;

  modport master (
    input  req_valid,
    input  req_data,
    output req_ready,
    output cdb_valid,
    output cdb_data
  );

  modport slave (
    output req_valid,
    output req_data,
    input  req_ready,
    input  cdb_valid,
    input  cdb_data
  );

endinterface

// File: rtl/cdb_rr_select.sv
// Round-robin picker: first set request at or after rr_ptr+1, wrapping.
module cdb_rr_select #(
  parameter int NUM_FU = 4,
  parameter int IW     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [IW-1:0]     rr_ptr,
  output logic [NUM_FU-1:0] grant,
  output logic [IW-1:0]     idx
);

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_FU; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_FU);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one combinational grant per cycle, registered single-cycle broadcast.
// Define CDB_AGE_PRIO_EN to select oldest (smallest order) instead of round-robin.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU = TOTAL_FU
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  cdb_arbiter_if.master                     bus,
  output logic [31:0]                       conflict_cnt,
  output logic [((NUM_FU > 1) ? $clog2(NUM_FU) : 1)-1:0] dbg_rr_ptr
);

  localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     sel_idx;
  logic [NUM_FU-1:0] sel_grant;
  logic [NUM_FU-1:0] grant;
  cdb_entry_t        granted_entry;

`ifdef CDB_AGE_PRIO_EN
  // Strict less-than keeps the lowest index on equal order values.
  always_comb begin : age_select
    logic               found;
    logic [ORDER_W-1:0] best;
    found     = 1'b0;
    best      = '0;
    sel_grant = '0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (bus.req_valid[IW'(i)] &&
          (!found || (bus.req_data[IW'(i)].order < best))) begin
        found   = 1'b1;
        best    = bus.req_data[IW'(i)].order;
        sel_idx = IW'(i);
      end
    end
    if (found) sel_grant[sel_idx] = 1'b1;
  end
`else
  cdb_rr_select #(
    .NUM_FU (NUM_FU),
    .IW     (IW)
  ) u_rr_select (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr),
    .grant  (sel_grant),
    .idx    (sel_idx)
  );
`endif

  assign grant         = (rst || flush) ? '0 : sel_grant;
  assign bus.req_ready = grant;
  assign dbg_rr_ptr    = rr_ptr;

  always_comb begin
    granted_entry       = bus.req_data[sel_idx];
    granted_entry.fu_id = fu_id_t'(sel_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_data  <= '0;
      rr_ptr        <= IW'(NUM_FU - 1);
      conflict_cnt  <= '0;
    end else begin
      // Contention is counted even while flushing; the counter sticks at all-ones.
      if (($countones(bus.req_valid) > 1) && (conflict_cnt != 32'hFFFF_FFFF))
        conflict_cnt <= conflict_cnt + 32'd1;
      if (|grant) begin
        bus.cdb_valid <= 1'b1;
        bus.cdb_data  <= granted_entry;
        rr_ptr        <= sel_idx;
      end else begin
        bus.cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed literal cases plus random traffic vs. a behavioural model.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int N  = TOTAL_FU;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [31:0]   conflict_cnt;
  logic [IW-1:0] dbg_rr_ptr;

  cdb_arbiter_if #(.NUM_FU(N)) bus ();

  cdb_arbiter #(.NUM_FU(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .conflict_cnt (conflict_cnt),
    .dbg_rr_ptr   (dbg_rr_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: state as seen after the most recent posedge
  logic [44:0] exp_q[$];
  logic        m_valid = 1'b0;
  cdb_entry_t  m_last  = '0;
  int          m_ptr   = N - 1;
  longint      m_cnt   = 0;
  int          m_wait[N];

  function automatic int model_pick();
    int best;
    best = -1;
`ifdef CDB_AGE_PRIO_EN
    for (int i = 0; i < N; i++)
      if (bus.req_valid[i] && (best < 0 || bus.req_data[i].order < bus.req_data[best].order))
        best = i;
`else
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (best < 0 && bus.req_valid[j]) best = j;
    end
`endif
    return best;
  endfunction

  // scoreboard: compare every cycle, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    int          g;
    int          nv;
    logic [N-1:0] exp_ready;
    cdb_entry_t  e;
    g = (rst || flush) ? -1 : model_pick();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("model_ready", bus.req_ready, exp_ready);
    chk("model_cdb_valid", bus.cdb_valid, m_valid);
    if (m_valid && exp_q.size() > 0) m_last = exp_q.pop_front();
    chk("model_cdb_data", bus.cdb_data, m_last);
    chk("model_conflict_cnt", conflict_cnt, m_cnt[31:0]);
    chk("model_rr_ptr", dbg_rr_ptr, m_ptr[IW-1:0]);

    nv = $countones(bus.req_valid);
    if (rst) begin
      m_valid = 1'b0;
      m_last  = '0;
      m_ptr   = N - 1;
      m_cnt   = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else begin
      if (nv > 1 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (g >= 0) begin
        e = bus.req_data[g];
        e.fu_id = fu_id_t'(g);
        exp_q.push_back(e);
        m_valid = 1'b1;
        m_ptr = g;
`ifndef CDB_AGE_PRIO_EN
        chk("rr_wait_bound", 64'(m_wait[g] <= N - 1), 64'd1);
`endif
        for (int i = 0; i < N; i++)
          if (i == g) m_wait[i] = 0;
          else if (bus.req_valid[i]) m_wait[i]++;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [4:0] rd, input logic [31:0] data,
                        input logic [ORDER_W-1:0] order);
    bus.req_valid[i]      = 1'b1;
    bus.req_data[i].fu_id = fu_id_t'($urandom_range(0, N - 1));
    bus.req_data[i].rd    = rd;
    bus.req_data[i].data  = data;
    bus.req_data[i].order = order;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  logic [N-1:0] g_seen;
  int           rr_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // idle after reset
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_cdb_valid", bus.cdb_valid, 0);
      chk("idle_conflict_cnt", conflict_cnt, 0);
      next_cycle();
    end

    // single requester FU2: zero-latency grant, one-cycle broadcast
    set_fu(2, 5'd5, 32'hDEAD_BEEF, 6'd0);
    @(negedge clk);
    chk("single_ready", bus.req_ready, 4'b0100);
    next_cycle();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_cdb_valid", bus.cdb_valid, 1);
    chk("single_fu_id", bus.cdb_data.fu_id, 2);
    chk("single_rd", bus.cdb_data.rd, 5);
    chk("single_data", bus.cdb_data.data, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    chk("single_cdb_drop", bus.cdb_valid, 0);
    chk("single_data_hold", bus.cdb_data.data, 32'hDEAD_BEEF);
    next_cycle();

    do_reset();
`ifdef CDB_AGE_PRIO_EN
    set_fu(1, 5'd1, 32'h1111_0001, 6'd10);
    set_fu(3, 5'd3, 32'h3333_0003, 6'd7);
    @(negedge clk);
    chk("age_first", bus.req_ready, 4'b1000);
    next_cycle();
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    chk("age_second", bus.req_ready, 4'b0010);
    next_cycle();
    bus.req_valid = '0;
`else
    for (int i = 0; i < N; i++) set_fu(i, 5'(i + 1), $urandom, 6'd0);
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] exp_onehot;
      exp_onehot = '0;
      exp_onehot[rr_seq[k]] = 1'b1;
      @(negedge clk);
      chk("rr_order", bus.req_ready, exp_onehot);
      chk("rr_conflict_cnt", conflict_cnt, k);
      next_cycle();
    end
    bus.req_valid = '0;
`endif
    next_cycle();

    // flush: in-flight broadcast completes, new grants blocked
    do_reset();
    set_fu(0, 5'd8, 32'h0000_00F0, 6'd3);
    @(negedge clk);
    chk("flush_pre_grant", bus.req_ready, 4'b0001);
    next_cycle();
    bus.req_valid = '0;
    set_fu(1, 5'd9, 32'h0000_00F1, 6'd4);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_cdb_valid", bus.cdb_valid, 1);
    chk("flush_cdb_fu", bus.cdb_data.fu_id, 0);
    chk("flush_ready", bus.req_ready, 4'b0000);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_after_valid", bus.cdb_valid, 0);
    chk("flush_after_ready", bus.req_ready, 4'b0010);
    next_cycle();
    bus.req_valid = '0;
    next_cycle();

    // reset beats a pending request
    set_fu(0, 5'd2, 32'h0BAD_CAFE, 6'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 4'b0000);
    next_cycle();
    rst = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("rst_cdb_valid", bus.cdb_valid, 0);
    chk("rst_rr_ptr", dbg_rr_ptr, N - 1);
    next_cycle();

    // random traffic; each FU holds its entry until granted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g_seen = bus.req_ready;
      next_cycle();
      for (int i = 0; i < N; i++) begin
        if (g_seen[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && $urandom_range(0, 99) < 45)
          set_fu(i, 5'($urandom_range(0, 31)), $urandom, 6'($urandom_range(0, 63)));
      end
      flush = ($urandom_range(0, 99) < 6);
      rst   = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    flush = 1'b0;
    bus.req_valid = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("drain_cdb_valid", bus.cdb_valid, 0);
    chk("drain_queue_empty", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
